// File: rtl/buft_pkg.sv
//------------------------------------------------------------------------------
// buft_pkg : shared defaults and the parity helper for the buft elastic buffer
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package buft_pkg;

  localparam int BUFT_DEF_WIDTH  = 8;
  localparam int BUFT_DEF_DEPTH  = 4;
  localparam int BUFT_PAR_MAX_W  = 256;

  // Zero-extension does not change parity, so callers pad narrower words.
  function automatic logic even_parity(input logic [BUFT_PAR_MAX_W-1:0] vec);
    return ^vec;
  endfunction

endpackage : buft_pkg

`default_nettype wire

// File: rtl/buft_ram.sv
//------------------------------------------------------------------------------
// buft_ram : DEPTH x DW register array, one write port, one combinational read
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

module buft_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule : buft_ram

`default_nettype wire

// File: rtl/buft_fifo.sv
//------------------------------------------------------------------------------
// buft_fifo : parametrised valid/ready elastic buffer with fill count, sticky
//             overflow and synchronous flush. Optional BUFT_PARITY_EN adds a
//             stored even-parity bit per entry and a sticky par_err output.
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

module buft_fifo
  import buft_pkg::*;
#(
  parameter int WIDTH = BUFT_DEF_WIDTH,
  parameter int DEPTH = BUFT_DEF_DEPTH,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
`ifdef BUFT_PARITY_EN
  output logic             par_err,
`endif
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
`ifdef BUFT_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int DW = WIDTH + PW;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push, pop, wr_en;
  logic [DW-1:0] wr_word, rd_word;

  assign in_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & ~flush;

`ifdef BUFT_PARITY_EN
  logic par_err_q, par_err_d;
  logic par_bad;

  assign wr_word  = {even_parity(BUFT_PAR_MAX_W'(in_data)), in_data};
  assign par_bad  = rd_word[WIDTH] != even_parity(BUFT_PAR_MAX_W'(rd_word[WIDTH-1:0]));

  always_comb begin
    par_err_d = par_err_q | (pop & ~flush & par_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign wr_word = in_data;
`endif

  buft_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_word),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // A refused write is recorded even in a flush cycle.
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data = rd_word[WIDTH-1:0];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule : buft_fifo

`default_nettype wire
